sysid_info_regs: RTL and testbench

Parameterised system-identification and uptime register block on the Avalon-MM control bus of the Qsys system. Extends the fixed single-word system ID with a word-addressed register file: read-only ID and build timestamp, a 64-bit prescaled uptime counter with coherent high-word snapshot, a programmable prescaler, and byte-writable scratch registers. Read latency is fixed at one cycle with `readdatavalid`. Host software uses it to identify the image, measure elapsed time and probe bus health.

---
 rtl/sysid_info_regs.sv | 120 ++++++++++++
 tb/tb_sysid_info_regs.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/sysid_info_regs.sv
// sysid_info_regs: system ID / build timestamp / prescaled 64-bit uptime /
// scratch register file on an Avalon-MM slave with fixed 1-cycle read latency.
module sysid_info_regs #(
  parameter logic [31:0] SYSID         = 32'h550B_D444,
  parameter logic [31:0] TIMESTAMP     = 32'd0,
  parameter logic [31:0] PRESCALE_INIT = 32'd0,
  parameter int          NUM_SCRATCH   = 2
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [2:0]  address,
  input  logic        read,
  input  logic        write,
  input  logic [31:0] writedata,
  input  logic [3:0]  byteenable,
  output logic [31:0] readdata,
  output logic        readdatavalid
);

  localparam logic [2:0] A_ID      = 3'd0;
  localparam logic [2:0] A_TSTAMP  = 3'd1;
  localparam logic [2:0] A_UP_LO   = 3'd2;
  localparam logic [2:0] A_UP_HI   = 3'd3;
  localparam logic [2:0] A_PRESC   = 3'd4;
  localparam int         A_SCR0    = 5;

  logic [31:0]                  rdata_q, rdata_d;
  logic                         rvalid_q, rvalid_d;
  logic [63:0]                  uptime_q, uptime_d;
  logic [31:0]                  shadow_q, shadow_d;
  logic [31:0]                  pcnt_q, pcnt_d;
  logic [31:0]                  prescale_q, prescale_d;
  logic [NUM_SCRATCH-1:0][31:0] scratch_q, scratch_d;
  logic [31:0]                  rd_mux;
  logic [31:0]                  be_mask;

  // Expand byteenable into a per-bit write mask
  always_comb begin
    be_mask = '0;
    for (int b = 0; b < 4; b++) begin
      be_mask[8*b +: 8] = {8{byteenable[b]}};
    end
  end

  // Read mux over the pre-edge register state (same-address RMW returns old value)
  always_comb begin
    rd_mux = '0;
    case (address)
      A_ID:     rd_mux = SYSID;
      A_TSTAMP: rd_mux = TIMESTAMP;
      A_UP_LO:  rd_mux = uptime_q[31:0];
      A_UP_HI:  rd_mux = shadow_q;
      A_PRESC:  rd_mux = prescale_q;
      default: begin
        for (int i = 0; i < NUM_SCRATCH; i++) begin
          if (address == 3'(A_SCR0 + i)) rd_mux = scratch_q[i];
        end
      end
    endcase
  end

  // Next-state: read pipeline, snapshot, prescaled uptime, RW registers
  always_comb begin
    rdata_d    = rdata_q;
    rvalid_d   = read;
    uptime_d   = uptime_q;
    shadow_d   = shadow_q;
    pcnt_d     = pcnt_q;
    prescale_d = prescale_q;
    scratch_d  = scratch_q;

    if (read) rdata_d = rd_mux;
    // Shadow takes the pre-increment high word so LO/HI stay coherent
    if (read && address == A_UP_LO) shadow_d = uptime_q[63:32];

    if (pcnt_q == prescale_q) begin
      pcnt_d   = '0;
      uptime_d = uptime_q + 64'd1;
    end else begin
      pcnt_d   = pcnt_q + 32'd1;
    end

    if (write) begin
      if (address == A_PRESC) begin
        prescale_d = (prescale_q & ~be_mask) | (writedata & be_mask);
        // Restart the period on any PRESCALE write, even with byteenable 0
        pcnt_d     = '0;
      end
      for (int i = 0; i < NUM_SCRATCH; i++) begin
        if (address == 3'(A_SCR0 + i))
          scratch_d[i] = (scratch_q[i] & ~be_mask) | (writedata & be_mask);
      end
    end
  end

  // State registers; reset edge overrides every update including a pending read
  always_ff @(posedge clock) begin
    if (reset) begin
      rdata_q    <= '0;
      rvalid_q   <= 1'b0;
      uptime_q   <= '0;
      shadow_q   <= '0;
      pcnt_q     <= '0;
      prescale_q <= PRESCALE_INIT;
      scratch_q  <= '0;
    end else begin
      rdata_q    <= rdata_d;
      rvalid_q   <= rvalid_d;
      uptime_q   <= uptime_d;
      shadow_q   <= shadow_d;
      pcnt_q     <= pcnt_d;
      prescale_q <= prescale_d;
      scratch_q  <= scratch_d;
    end
  end

  assign readdata      = rdata_q;
  assign readdatavalid = rvalid_q;

endmodule

// File: tb/tb_sysid_info_regs.sv
// Bench for sysid_info_regs: directed scenarios plus random traffic, all
// checked against a transaction-level model of the register map.
module tb_sysid_info_regs;

  localparam logic [31:0] SYSID = 32'h550B_D444;
  localparam logic [31:0] TS    = 32'h6502_1234;
  localparam logic [31:0] PI    = 32'd0;
  localparam int          NS    = 2;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [2:0]  address = '0;
  logic        read = 1'b0, write = 1'b0;
  logic [31:0] writedata = '0;
  logic [3:0]  byteenable = '0;
  logic [31:0] readdata;
  logic        readdatavalid;

  int checks = 0;
  int passed = 0;

  // Reference model state
  logic [63:0] m_up;
  logic [31:0] m_sh, m_pc, m_ps, m_rd;
  logic [31:0] m_scr [NS];
  logic        m_vld;

  sysid_info_regs #(.SYSID(SYSID), .TIMESTAMP(TS), .PRESCALE_INIT(PI), .NUM_SCRATCH(NS)) dut (
    .clock(clock), .reset(reset), .address(address), .read(read), .write(write),
    .writedata(writedata), .byteenable(byteenable),
    .readdata(readdata), .readdatavalid(readdatavalid)
  );

  always #5 clock = ~clock;

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                        input logic [3:0] be);
    logic [31:0] r = old;
    for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = wd[8*b +: 8];
    return r;
  endfunction

  function automatic logic [31:0] model_read(input int a);
    if (a == 0) return SYSID;
    if (a == 1) return TS;
    if (a == 2) return m_up[31:0];
    if (a == 3) return m_sh;
    if (a == 4) return m_ps;
    if (a >= 5 && a < 5 + NS) return m_scr[a-5];
    return 32'd0;
  endfunction

  task automatic model_reset();
    m_up = '0; m_sh = '0; m_pc = '0; m_ps = PI; m_rd = '0; m_vld = 1'b0;
    for (int i = 0; i < NS; i++) m_scr[i] = '0;
  endtask

  // One bus cycle: drive, clock, advance model, settle 1 time unit past edge
  task automatic cycle(input logic rd, input logic wr, input int a,
                       input logic [31:0] wd, input logic [3:0] be);
    read = rd; write = wr; address = 3'(a); writedata = wd; byteenable = be;
    @(posedge clock);
    if (rd) m_rd = model_read(a);
    m_vld = rd;
    if (rd && a == 2) m_sh = m_up[63:32];
    if (m_pc == m_ps) begin m_pc = 0; m_up = m_up + 64'd1; end
    else m_pc = m_pc + 32'd1;
    if (wr) begin
      if (a == 4) begin m_ps = merge(m_ps, wd, be); m_pc = 0; end
      else if (a >= 5 && a < 5 + NS) m_scr[a-5] = merge(m_scr[a-5], wd, be);
    end
    #1;
    read = 1'b0; write = 1'b0;
  endtask

  task automatic force_uptime(input logic [63:0] v);
    force dut.uptime_q = v;
    #1;
    release dut.uptime_q;
    m_up = v;
  endtask

  task automatic test_reset();
    reset = 1'b1; read = 1'b1; address = 3'd0;
    @(posedge clock); #1;
    reset = 1'b0; read = 1'b0;
    model_reset();
    checks++;
    if (readdata !== 32'd0 || readdatavalid !== 1'b0)
      $display("FAIL reset_state got %h/%b exp 00000000/0", readdata, readdatavalid);
    else passed++;
    for (int a = 0; a < 8; a++) begin
      cycle(1, 0, a, 0, 0);
      checks++;
      if (readdata !== m_rd || readdatavalid !== 1'b1)
        $display("FAIL reset_readout a=%0d got %h/%b exp %h/1", a, readdata, readdatavalid, m_rd);
      else passed++;
    end
    cycle(0, 0, 0, 0, 0);
    checks++;
    if (readdatavalid !== 1'b0 || readdata !== m_rd)
      $display("FAIL readout_idle got %h/%b exp %h/0", readdata, readdatavalid, m_rd);
    else passed++;
  endtask

  task automatic test_byte_enable();
    cycle(0, 1, 5, 32'hA5A5_A5A5, 4'b1111);
    cycle(0, 1, 5, 32'h0000_3C00, 4'b0010);
    cycle(1, 0, 5, 0, 0);
    checks++;
    if (readdata !== 32'hA5A5_3CA5 || readdata !== m_rd || readdatavalid !== 1'b1)
      $display("FAIL byte_enable got %h/%b exp a5a53ca5/1", readdata, readdatavalid);
    else passed++;
    cycle(0, 1, 0, 32'h1234_5678, 4'b1111);
    cycle(1, 0, 0, 0, 0);
    checks++;
    if (readdata !== SYSID)
      $display("FAIL ro_write_id got %h exp %h", readdata, SYSID);
    else passed++;
  endtask

  task automatic test_prescale();
    logic [31:0] start;
    int fails = 0;
    cycle(0, 1, 4, 32'd3, 4'b0001);
    cycle(1, 0, 2, 0, 0);
    start = readdata;
    for (int i = 0; i < 100; i++) begin
      cycle(1, 0, 2, 0, 0);
      if (readdata !== m_rd) begin
        fails++;
        $display("FAIL prescale3 i=%0d got %h exp %h", i, readdata, m_rd);
      end
    end
    checks++;
    if (fails == 0) passed++;
    checks++;
    if (readdata - start !== 32'd25)
      $display("FAIL prescale3_count got %0d exp 25", readdata - start);
    else passed++;
    // Rewrite mid-period: next tick exactly 4 edges after the write edge
    cycle(0, 0, 0, 0, 0);
    cycle(0, 1, 4, 32'd3, 4'b0001);
    cycle(1, 0, 2, 0, 0);
    start = readdata;
    for (int i = 0; i < 4; i++) cycle(1, 0, 2, 0, 0);
    checks++;
    if (readdata !== m_rd || readdata !== start + 32'd1)
      $display("FAIL prescale_rewrite got %h exp %h", readdata, start + 32'd1);
    else passed++;
  endtask

  task automatic test_uptime_carry();
    cycle(0, 1, 4, 32'd0, 4'b1111);
    force_uptime(64'h0000_0000_FFFF_FFFF);
    cycle(0, 0, 0, 0, 0);
    cycle(1, 0, 2, 0, 0);
    checks++;
    if (readdata !== 32'h0 || readdata !== m_rd)
      $display("FAIL carry_lo got %h exp 00000000", readdata);
    else passed++;
    cycle(1, 0, 3, 0, 0);
    checks++;
    if (readdata !== 32'h1 || readdata !== m_rd)
      $display("FAIL carry_hi got %h exp 00000001", readdata);
    else passed++;
    force_uptime(64'h0000_0000_FFFF_FFFF);
    cycle(1, 0, 2, 0, 0);
    checks++;
    if (readdata !== 32'hFFFF_FFFF)
      $display("FAIL coherent_lo got %h exp ffffffff", readdata);
    else passed++;
    cycle(1, 0, 3, 0, 0);
    checks++;
    if (readdata !== 32'h0 || readdata !== m_rd)
      $display("FAIL coherent_hi got %h exp 00000000", readdata);
    else passed++;
    force_uptime(64'hFFFF_FFFF_FFFF_FFFF);
    cycle(0, 0, 0, 0, 0);
    cycle(1, 0, 2, 0, 0);
    cycle(1, 0, 3, 0, 0);
    checks++;
    if (readdata !== 32'h0 || m_sh !== 32'h0)
      $display("FAIL wrap_hi got %h exp 00000000", readdata);
    else passed++;
  endtask

  task automatic test_back_to_back();
    cycle(0, 1, 6, 32'hDEAD_BEEF, 4'b1111);
    cycle(1, 1, 6, 32'h0BAD_F00D, 4'b1111);
    checks++;
    if (readdata !== 32'hDEAD_BEEF || readdatavalid !== 1'b1)
      $display("FAIL same_cycle_old got %h/%b exp deadbeef/1", readdata, readdatavalid);
    else passed++;
    cycle(1, 0, 6, 0, 0);
    checks++;
    if (readdata !== 32'h0BAD_F00D || readdata !== m_rd)
      $display("FAIL same_cycle_new got %h exp 0badf00d", readdata);
    else passed++;
  endtask

  task automatic test_random();
    int fails = 0;
    for (int i = 0; i < 400; i++) begin
      logic rd, wr;
      int a;
      logic [31:0] wd;
      rd = 1'($urandom_range(0, 1));
      wr = 1'($urandom_range(0, 1));
      a  = $urandom_range(0, 7);
      wd = (a == 4) ? 32'($urandom_range(0, 5)) : $urandom;
      cycle(rd, wr, a, wd, 4'($urandom));
      if (readdata !== m_rd || readdatavalid !== m_vld) begin
        fails++;
        $display("FAIL random i=%0d a=%0d got %h/%b exp %h/%b", i, a, readdata, readdatavalid, m_rd, m_vld);
      end
    end
    checks++;
    if (fails == 0) passed++;
  endtask

  task automatic test_reset_mid();
    cycle(0, 1, 5, 32'h1111_2222, 4'b1111);
    cycle(0, 1, 4, 32'd2, 4'b1111);
    reset = 1'b1; read = 1'b1; address = 3'd5;
    @(posedge clock); #1;
    reset = 1'b0; read = 1'b0;
    model_reset();
    checks++;
    if (readdatavalid !== 1'b0 || readdata !== 32'd0)
      $display("FAIL reset_mid got %h/%b exp 00000000/0", readdata, readdatavalid);
    else passed++;
    for (int a = 2; a < 8; a++) begin
      cycle(1, 0, a, 0, 0);
      checks++;
      if (readdata !== m_rd || readdatavalid !== 1'b1)
        $display("FAIL reset_mid_reg a=%0d got %h exp %h", a, readdata, m_rd);
      else passed++;
    end
  endtask

  initial begin
    model_reset();
    repeat (2) @(posedge clock);
    #1;
    test_reset();
    test_byte_enable();
    test_prescale();
    test_uptime_carry();
    test_back_to_back();
    test_random();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
